// File: rtl/sap_register_bank.sv
// General-purpose register bank for the 16-bit SAP datapath: NUM_REGS bus-loadable
// registers with in-place INC/DEC/SHL/SHR/CLR, two combinational read ports and carry/zero flags.
module sap_register_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] op_sel,
  input  logic [WIDTH-1:0] bus,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             carry,
  output logic             zero,
  output logic             op_valid
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] result;
  logic             res_carry;
  logic             sel_ok;
  logic             is_op;
  logic             apply;
  op_e              op_code;

  assign op_code = op_e'(op);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cur    = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (op_sel == SEL_W'(i)) begin
        cur    = regs[i];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    result    = cur;
    res_carry = 1'b0;
    is_op     = 1'b1;
    case (op_code)
      OP_LOAD: result = bus;
      OP_INC:  {res_carry, result} = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin
        result    = cur - {{(WIDTH-1){1'b0}}, 1'b1};
        res_carry = (cur == '0);
      end
      OP_SHL: begin
        result    = {cur[WIDTH-2:0], 1'b0};
        res_carry = cur[WIDTH-1];
      end
      OP_SHR: begin
        result    = {1'b0, cur[WIDTH-1:1]};
        res_carry = cur[0];
      end
      OP_CLR:  result = '0;
      default: is_op = 1'b0;  // NOP and the reserved code
    endcase
  end

  // An out-of-range target behaves like NOP: flags hold, op_valid drops.
  assign apply = sel_ok && is_op;

  // NOTE: the register array sits under the async reset because reset must clear every
  // register; a RAM-style array without reset would not meet that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= apply;
      if (apply) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (op_sel == SEL_W'(i)) regs[i] <= result;
        end
        carry <= res_carry;
        zero  <= (result == '0);
      end
    end
  end

  // Reads come straight from state: a register being modified shows its old value until the edge.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SEL_W'(i)) out_a = regs[i];
      if (rd_sel_b == SEL_W'(i)) out_b = regs[i];
    end
  end

endmodule

// File: tb/tb_sap_register_bank.sv
// Scoreboard bench for sap_register_bank: a 4-register and a 3-register instance share the
// stimulus; an arithmetic reference model predicts both, and a monitor compares after each edge.
module tb_sap_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [1:0]  op_sel;
  logic [15:0] bus;
  logic [1:0]  rd_sel_a;
  logic [1:0]  rd_sel_b;

  logic [15:0] out_a4, out_b4, out_a3, out_b3;
  logic        carry4, zero4, valid4, carry3, zero3, valid3;

  always #5 clk = ~clk;

  sap_register_bank #(.WIDTH(16), .NUM_REGS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .op(op), .op_sel(op_sel), .bus(bus),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .out_a(out_a4), .out_b(out_b4),
    .carry(carry4), .zero(zero4), .op_valid(valid4)
  );

  sap_register_bank #(.WIDTH(16), .NUM_REGS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .op(op), .op_sel(op_sel), .bus(bus),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .out_a(out_a3), .out_b(out_b3),
    .carry(carry3), .zero(zero3), .op_valid(valid3)
  );

  // Reference model: index 0 mirrors the 4-register build, index 1 the 3-register build.
  int m_reg [2][4];
  bit m_c [2];
  bit m_z [2];
  bit m_v [2];
  int nregs [2] = '{4, 3};

  typedef struct {
    logic [15:0] a0, b0, a1, b1;
    logic        c0, z0, v0, c1, z1, v1;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_read(input int k, input int sel);
    return (sel < nregs[k]) ? m_reg[k][sel] : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
      m_c[k] = 0; m_z[k] = 0; m_v[k] = 0;
    end
  endfunction

  function automatic void model_apply(input int k, input int o, input int sel, input int d);
    int v, n;
    bit c;
    if (o == 0 || o == 7 || sel >= nregs[k]) begin
      m_v[k] = 0;
      return;
    end
    v = m_reg[k][sel];
    case (o)
      1: begin n = d;                   c = 0;              end
      2: begin n = (v + 1) % 65536;     c = (v == 65535);   end
      3: begin n = (v + 65535) % 65536; c = (v == 0);       end
      4: begin n = (v * 2) % 65536;     c = (v >= 32768);   end
      5: begin n = v / 2;               c = (v % 2 == 1);   end
      default: begin n = 0;             c = 0;              end
    endcase
    m_reg[k][sel] = n;
    m_c[k] = c;
    m_z[k] = (n == 0);
    m_v[k] = 1;
  endfunction

  // Drive one op between edges, update the model and queue what should be seen after the edge.
  task automatic step(input string tag, input int o, input int s, input int d,
                      input int ra, input int rb, input bit pre_check = 0);
    exp_t e;
    @(negedge clk);
    op = 3'(o); op_sel = 2'(s); bus = 16'(d); rd_sel_a = 2'(ra); rd_sel_b = 2'(rb);
    if (pre_check) begin
      #1;
      check({tag, " pre-edge out_a"}, 32'(out_a4), 32'(model_read(0, ra)));
    end
    for (int k = 0; k < 2; k++) model_apply(k, o, s, d);
    e.a0 = 16'(model_read(0, ra)); e.b0 = 16'(model_read(0, rb));
    e.a1 = 16'(model_read(1, ra)); e.b1 = 16'(model_read(1, rb));
    e.c0 = m_c[0]; e.z0 = m_z[0]; e.v0 = m_v[0];
    e.c1 = m_c[1]; e.z1 = m_z[1]; e.v1 = m_v[1];
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_a4"}, 32'(out_a4), 0);
    check({tag, " out_a3"}, 32'(out_a3), 0);
    check({tag, " carry"},  32'({carry4, carry3}), 0);
    check({tag, " zero"},   32'({zero4, zero3}), 0);
    check({tag, " valid"},  32'({valid4, valid3}), 0);
  endtask

  // Monitor: results are visible just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " out_a[4]"}, 32'(out_a4), 32'(e.a0));
        check({e.tag, " out_b[4]"}, 32'(out_b4), 32'(e.b0));
        check({e.tag, " flags[4]"}, 32'({carry4, zero4, valid4}), 32'({e.c0, e.z0, e.v0}));
        check({e.tag, " out_a[3]"}, 32'(out_a3), 32'(e.a1));
        check({e.tag, " out_b[3]"}, 32'(out_b3), 32'(e.b1));
        check({e.tag, " flags[3]"}, 32'({carry3, zero3, valid3}), 32'({e.c1, e.z1, e.v1}));
      end
    end
  end

  initial begin
    rst = 1'b0; op = '0; op_sel = '0; bus = '0; rd_sel_a = '0; rd_sel_b = '0;
    model_reset();
    #3;
    check_reset_state("power-on reset");
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream must clear immediately, between edges.
    step("load r1", 1, 1, 400, 1, 0);
    @(negedge clk);
    op = '0; rd_sel_a = 2'd1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    rst = 1'b1;

    step("load r0",    1, 0, 400,      0, 2);
    step("load r2",    1, 2, 16'hBEEF, 0, 2);
    step("nop r1/r3",  0, 0, 0,        1, 3);

    step("load r3",    1, 3, 16'hFFFF, 3, 2);
    step("inc wrap",   2, 3, 0,        3, 2);
    step("dec wrap",   3, 3, 0,        3, 2);

    step("load r1",    1, 1, 16'h8001, 1, 0);
    step("shl",        4, 1, 0,        1, 0);
    step("shr",        5, 1, 0,        1, 0);
    step("shr to 0",   5, 1, 0,        1, 0);

    step("load r0=5",  1, 0, 5,        0, 1);
    step("inc r0",     2, 0, 0,        0, 1, 1'b1);
    step("nop hold",   0, 0, 0,        0, 1);

    step("load sel3",  1, 3, 16'h1234, 3, 0);
    step("rsvd op",    7, 0, 16'h5555, 3, 0);
    step("clr r2",     6, 2, 0,        2, 3);

    for (int i = 0; i < 300; i++) begin
      step("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_register_bank.md
Name: sap_register_bank

Overview:
- Parametrised general-purpose register bank for the 16-bit SAP datapath; generalises the single B register into NUM_REGS bus-loadable registers.
- Each register supports in-place operations (increment, decrement, shift, clear) in addition to loading from the bus.
- Two independent read ports feed the ALU operand latches and the bus driver.
- A carry flag and a zero flag from the last executed operation are registered for the control unit.

Parameters:
- WIDTH, 16, data width of each register, bus and read ports
- NUM_REGS, 4, number of registers (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_REGS

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset; low clears all state immediately
- op  input  3  operation code (see Behaviour)
- op_sel  input  SEL_W  target register index for op
- bus  input  WIDTH  data source for LOAD
- rd_sel_a  input  SEL_W  read port A select
- rd_sel_b  input  SEL_W  read port B select
- out_a  output  WIDTH  contents of register rd_sel_a
- out_b  output  WIDTH  contents of register rd_sel_b
- carry  output  1  registered carry/borrow/shifted-out bit of last op
- zero  output  1  registered; 1 when the result of the last op is 0
- op_valid  output  1  registered; 1 for one cycle after a legal op was applied

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, carry = 0, zero = 0, op_valid = 0. This holds regardless of clk and applies even mid-operation. Release is synchronous to the next rising edge; the first op is accepted on the first edge with rst=1.
- Opcodes (applied on a rising edge to register op_sel):
  - 000 NOP: no register change; carry, zero and op_valid hold, except op_valid clears to 0.
  - 001 LOAD: R <= bus; carry <= 0.
  - 010 INC: R <= R+1 mod 2**WIDTH; carry <= 1 only when R was all-ones (wrap to 0).
  - 011 DEC: R <= R-1 mod 2**WIDTH; carry (borrow) <= 1 only when R was 0 (wrap to all-ones).
  - 100 SHL: R <= {R[WIDTH-2:0],0}; carry <= old R[WIDTH-1].
  - 101 SHR: R <= {0,R[WIDTH-1:1]}; carry <= old R[0].
  - 110 CLR: R <= 0; carry <= 0.
  - 111 reserved: treated as NOP.
- For every non-NOP legal op: zero <= (new R == 0) and op_valid <= 1.
- Latency: single cycle; the result is visible on read ports in the cycle after the edge.
- Reads are combinational from the register state, with no write bypass. Reading the register being modified returns the old value until the edge.
- Out-of-range select:
  - op_sel >= NUM_REGS: op is ignored; registers, carry and zero are unchanged; op_valid <= 0.
  - rd_sel >= NUM_REGS: the port returns 0.
- Only one register is modified per cycle; other registers hold.
- rd_sel_a == rd_sel_b is legal; both ports show the same value.

Test Plan:
- Reset mid-stream: load R1=16'd400, pull rst low between edges -> out_a (sel 1)=0, carry=0, zero=0, op_valid=0 immediately, before the next edge.
- LOAD/read: LOAD R0=16'd400, LOAD R2=16'hBEEF, rd_sel_a=0, rd_sel_b=2 -> out_a=16'd400, out_b=16'hBEEF, op_valid=1, zero=0; R1 and R3 remain 0.
- Wrap-around:
  - LOAD R3=16'hFFFF, then INC R3 -> R3=0, carry=1, zero=1.
  - Then DEC R3 -> R3=16'hFFFF, carry=1, zero=0.
- Shifts: LOAD R1=16'h8001; SHL -> 16'h0002, carry=1; SHR -> 16'h0001, carry=0; SHR -> 0, carry=1, zero=1.
- Read-during-op: R0=5, op=INC on R0 with rd_sel_a=0 -> out_a=5 before the edge and 6 after it; NOP next cycle -> op_valid=0, zero and carry hold.
- Illegal: NUM_REGS=3 build, op=LOAD with op_sel=3, bus=16'h1234 -> no register changes, op_valid=0, flags hold; rd_sel_a=3 -> out_a=0; opcode 111 -> treated as NOP.
